btn_debounce: RTL and testbench



---
 rtl/board_io_pkg.sv | 9 +
 rtl/btn_debounce_ch.sv | 51 +++++
 rtl/btn_debounce.sv | 30 +++
 tb/tb_btn_debounce.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Board-level I/O constants shared by the button/LED front-end blocks.
package board_io_pkg;

  localparam int CLK_HZ                  = 100_000_000;
  localparam int N_BTN                   = 4;
  // 10 ms at CLK_HZ
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stability counter, debounced level
// and registered press/release strobes.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      stable      <= 1'b0;
      cnt         <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      // A single agreeing sample throws away the whole run.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable      <= s2;
        cnt         <= '0;
        btn_press   <= s2;
        btn_release <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign btn_level = stable;

endmodule

// File: rtl/btn_debounce.sv
// Debounce front-end for the board push buttons; one independent
// btn_debounce_ch per button, wiring only at this level.
module btn_debounce #(
  parameter int N_BTN           = board_io_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing, checked
// against a sliding-window model of the debounce rule.
module tb_btn_debounce;

  localparam int N  = 4;
  localparam int DC = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  btn_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Model: raw samples per edge; the synchronizer makes the value seen at
  // edge k equal to the raw value sampled at edge k-2. The level flips once
  // the last DC seen values all differ from it.
  bit           raw_hist [N][$];
  bit           seen_hist[N][$];
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;

  int edge_n;
  int first_press  [N];
  int first_release[N];
  int n_press      [N];
  int n_release    [N];

  function automatic void model_clear();
    for (int c = 0; c < N; c++) begin
      raw_hist[c].delete();
      seen_hist[c].delete();
      first_press[c]   = -1;
      first_release[c] = -1;
      n_press[c]       = 0;
      n_release[c]     = 0;
    end
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    edge_n    = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r);
    m_press   = '0;
    m_release = '0;
    for (int c = 0; c < N; c++) begin
      bit seen;
      bit all_differ;
      raw_hist[c].push_back(r[c]);
      seen = (raw_hist[c].size() >= 3) ? raw_hist[c][raw_hist[c].size() - 3] : 1'b0;
      seen_hist[c].push_back(seen);
      if (raw_hist[c].size() > 4) void'(raw_hist[c].pop_front());
      if (seen_hist[c].size() > DC) void'(seen_hist[c].pop_front());
      all_differ = (seen_hist[c].size() == DC);
      foreach (seen_hist[c][j])
        if (seen_hist[c][j] == m_level[c]) all_differ = 1'b0;
      if (all_differ) begin
        m_level[c]   = ~m_level[c];
        m_press[c]   = m_level[c];
        m_release[c] = ~m_level[c];
      end
    end
  endfunction

  task automatic step(input logic [N-1:0] r);
    btn_raw = r;
    @(posedge clk);
    edge_n++;
    model_edge(r);
    #1;
    check("level",   btn_level,   m_level);
    check("press",   btn_press,   m_press);
    check("release", btn_release, m_release);
    for (int c = 0; c < N; c++) begin
      if (btn_press[c]) begin
        n_press[c]++;
        if (first_press[c] < 0) first_press[c] = edge_n;
      end
      if (btn_release[c]) begin
        n_release[c]++;
        if (first_release[c] < 0) first_release[c] = edge_n;
      end
    end
  endtask

  // Asserts reset between edges, checks the outputs clear with no clock,
  // then releases between edges so the next step is edge 1.
  task automatic do_reset(input logic [N-1:0] r);
    btn_raw = r;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level",   btn_level,   '0);
    check("async_rst_press",   btn_press,   '0);
    check("async_rst_release", btn_release, '0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [N-1:0] r;
    int           drop_edge;
    int           last_rise;
    btn_raw = '0;
    rst_n   = 1'b0;
    model_clear();
    #12;
    check("reset_level", btn_level, '0);
    check("reset_press", btn_press, '0);
    check("reset_rel",   btn_release, '0);
    rst_n = 1'b1;

    // Clean press on channel 0.
    for (int i = 0; i < 10; i++) step(4'b0001);
    check("clean_press_edge", first_press[0], 6);
    check("clean_press_once", n_press[0], 1);
    check("clean_no_release", n_release[0], 0);

    // Release on channel 3 from an accepted high level.
    do_reset('0);
    for (int i = 0; i < 8; i++) step(4'b1000);
    check("rel_setup_level", btn_level[3], 1'b1);
    drop_edge = edge_n + 1;
    for (int i = 0; i < 8; i++) step(4'b0000);
    check("release_edge", first_release[3], drop_edge + DC + 1);
    check("release_once", n_release[3], 1);

    // Bounce on channel 1: 1,0,1,0 then hold 1.
    do_reset('0);
    step(4'b0010); step(4'b0000); step(4'b0010); step(4'b0000);
    last_rise = edge_n + 1;
    for (int i = 0; i < 10; i++) step(4'b0010);
    check("bounce_press_edge", first_press[1], last_rise + DC + 1);
    check("bounce_press_once", n_press[1], 1);

    // Short glitch on channel 2: DC-1 cycles high.
    do_reset('0);
    for (int i = 0; i < DC - 1; i++) step(4'b0100);
    for (int i = 0; i < 10; i++) step(4'b0000);
    check("glitch_press",   n_press[2], 0);
    check("glitch_release", n_release[2], 0);
    check("glitch_level",   btn_level[2], 1'b0);

    // All four simultaneously.
    do_reset('0);
    for (int i = 0; i < 10; i++) step(4'b1111);
    for (int c = 0; c < N; c++) check("simul_press_edge", first_press[c], 6);
    check("simul_level", btn_level, 4'b1111);

    // Reset mid-qualification (count at 2), button held through release.
    do_reset('0);
    for (int i = 0; i < 4; i++) step(4'b0001);
    do_reset(4'b0001);
    for (int i = 0; i < 10; i++) step(4'b0001);
    check("rst_mid_press_edge", first_press[0], 6);
    check("rst_mid_press_once", n_press[0], 1);

    // Random bouncing in calm and noisy phases, with occasional resets.
    r = '0;
    for (int seg = 0; seg < 40; seg++) begin
      int noisy = $urandom_range(0, 2);
      int len   = $urandom_range(5, 40);
      for (int i = 0; i < len; i++) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, noisy == 0 ? 1 : 12) == 0) r[c] = ~r[c];
        step(r);
      end
      if ($urandom_range(0, 9) == 0) do_reset(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
